sr_cmd_driver: RTL and testbench
================================

# sr_cmd_driver

Command-side driver for the team's enable-gated SR flip-flop cell. Accepts set/reset/clear commands over a req/ack handshake and drives the cell's `s`, `r` and `en` inputs with an ordered sequence: data setup, then a timed enable pulse. It samples the cell's `q`/`q_bar` feedback at the end of the pulse and reports any mismatch. It sits between control logic and one SR flip-flop instance, so no caller ever drives the cell's raw inputs directly.

## Interface
- `SETUP_CYC`, default 1, cycles `s`/`r` are held stable with `en=0` before the pulse; legal range 1..15.
- `PULSE_CYC`, default 4, cycles `en` is held high; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: command request, sampled only in IDLE.
- `cmd` input 2: command code.
  - 10 = SET, drives s=1 r=0, expects q=1 q_bar=0.
  - 01 = RESET, drives s=0 r=1, expects q=0 q_bar=1.
  - 11 = CLEAR, drives s=1 r=1, expects q=0 q_bar=0.
  - 00 = illegal.
- `q_fb` input 1: cell `q` feedback.
- `q_bar_fb` input 1: cell `q_bar` feedback.
- `s` output 1: to cell `s`.
- `r` output 1: to cell `r`.
- `en` output 1: to cell `en`.
- `busy` output 1: high from accept until the cycle after ack.
- `ack` output 1: one-cycle completion pulse.
- `err` output 1: valid with `ack`; 1 = illegal cmd or feedback mismatch.
- `last_q` output 1: last successfully confirmed `q` value.

## Operation
- States: IDLE, SETUP, PULSE, DONE.
- IDLE: `s=r=en=0`, `busy=0`. When `req=1`:
  - Legal cmd: latch cmd and go to SETUP.
  - cmd=00: go to DONE with the error flag set; no pulse is driven.
- SETUP: drive the latched `s`/`r`, `en=0`. Hold for SETUP_CYC cycles, then go to PULSE.
- PULSE: same `s`/`r`, `en=1`. Hold for PULSE_CYC cycles.
  - On the clock edge that ends the last PULSE cycle, register `q_fb`/`q_bar_fb` and compare them with the expected pair.
  - Then go to DONE.
- DONE: `s=r=en=0`, `ack=1`, `err`=flag, `busy=1`. Next state is always IDLE.
- `last_q` updates in DONE only when `err=0` and the cmd was legal: SET gives 1, RESET and CLEAR give 0.
- `req` outside IDLE is ignored; commands are not queued.
- If `req` is still high in IDLE after DONE, it is accepted as a new command.
- `s`/`r` never change while `en=1`.
- `en` is never high unless exactly one legal cmd is latched.
- `s=r=0` with `en=1` is never driven.
- One 4-bit down-counter is shared by SETUP and PULSE; it reloads on each state entry.
- All outputs are registered.

## Timing
- Reset value of every output: `s=r=en=busy=ack=err=0`, `last_q=0`. State returns to IDLE.
- Reset asserted mid-operation forces all of the above immediately, without waiting for a clock edge. No `ack` is issued for the aborted command.
- `req` sampled high in IDLE at edge N:
  - `busy`, `s`, `r` valid from cycle N+1.
  - `en` high for cycles N+1+SETUP_CYC through N+SETUP_CYC+PULSE_CYC.
  - `ack` at cycle N+SETUP_CYC+PULSE_CYC+1.
- Latency from accept to ack is SETUP_CYC+PULSE_CYC+1 cycles: 6 with defaults.
- Illegal cmd: `ack=1`, `err=1` at cycle N+1; `busy` high in that cycle only.
- Back-to-back commands: the minimum spacing between accepts is latency+1 cycles, because one IDLE cycle is required.
- Feedback inputs are sampled only at the defined edge; glitches at any other time are ignored.

## Test plan
- Defaults, `req` with cmd=10 at cycle 0, bench models the cell (q_fb=1, q_bar_fb=0) -> `s=1 r=0` from cycle 1, `en=1` cycles 2–5, `ack=1 err=0` at cycle 6, `last_q=1` from cycle 7.
- cmd=01 with feedback stuck at q_fb=1, q_bar_fb=0 -> `ack` at cycle 6 with `err=1`; `last_q` stays 1.
- cmd=11, model gives q_fb=0, q_bar_fb=0 -> `err=0`, `last_q=0`. Check `s`/`r` are stable on every cycle `en=1`.
- cmd=00 -> `ack=1 err=1` at cycle 1, `en` never asserted, `busy` high for cycle 1 only.
- `req` held high continuously with cmd=10 -> accepts at cycles 0 and 7 and 14; `req` pulses during busy produce no extra `ack`.
- Assert `rst` asynchronously in the middle of cycle 3 during PULSE -> `en`, `s`, `r`, `busy` fall before the next edge. No `ack` follows. A new cmd after release completes normally with 6-cycle latency.
- SETUP_CYC=3, PULSE_CYC=1 -> `en` high at cycle 4 only, `ack` at cycle 5.

Source files
------------

// File: rtl/sr_cmd_driver.sv
// Command-side driver for the enable-gated SR flip-flop cell.
// Sequences data setup, a timed enable pulse, then checks q/q_bar feedback.
module sr_cmd_driver #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] cmd,
  input  logic       q_fb,
  input  logic       q_bar_fb,
  output logic       s,
  output logic       r,
  output logic       en,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic       last_q
);

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       exp_q;
  logic       exp_qb;
  logic       mismatch;

  // s/r still hold the latched command while in PULSE
  assign exp_qb   = r & ~s;
  assign mismatch = (q_fb != exp_q) || (q_bar_fb != exp_qb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      exp_q  <= 1'b0;
      s      <= 1'b0;
      r      <= 1'b0;
      en     <= 1'b0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          s    <= 1'b0;
          r    <= 1'b0;
          en   <= 1'b0;
          ack  <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (cmd == 2'b00) begin
              ack   <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              s     <= cmd[1];
              r     <= cmd[0];
              exp_q <= cmd[1] & ~cmd[0];
              cnt   <= SETUP_LD;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            en    <= 1'b1;
            cnt   <= PULSE_LD;
            state <= PULSE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            en    <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
            ack   <= 1'b1;
            err   <= mismatch;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // err is only clear here after a legal, confirmed command
          if (!err) last_q <= exp_q;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: vector table plus reset,
// back-to-back and non-default timing sequences.
module tb_sr_cmd_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req1, qf1, qbf1;
  logic [1:0] cmd1;
  logic       s1, r1, en1, busy1, ack1, err1, lq1;
  logic       req2, qf2, qbf2;
  logic [1:0] cmd2;
  logic       s2, r2, en2, busy2, ack2, err2, lq2;

  sr_cmd_driver dut (
    .clk(clk), .rst(rst), .req(req1), .cmd(cmd1),
    .q_fb(qf1), .q_bar_fb(qbf1),
    .s(s1), .r(r1), .en(en1), .busy(busy1),
    .ack(ack1), .err(err1), .last_q(lq1)
  );

  sr_cmd_driver #(.SETUP_CYC(3), .PULSE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .cmd(cmd2),
    .q_fb(qf2), .q_bar_fb(qbf2),
    .s(s2), .r(r2), .en(en2), .busy(busy2),
    .ack(ack2), .err(err2), .last_q(lq2)
  );

  int   compared = 0;
  int   mismatched = 0;
  logic lqm [2];

  typedef struct {
    logic [1:0] cmd;
    logic       qf;
    logic       qbf;
    logic       eerr;
    logic       elq;
  } vec_t;

  task automatic chk(input string nm, input logic [6:0] act,
                     input logic [6:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b want %b (s r en busy ack err last_q)",
               nm, act, exp);
    end
  endtask

  function automatic logic [6:0] outs(input bit sel);
    if (sel) return {s2, r2, en2, busy2, ack2, err2, lq2};
    return {s1, r1, en1, busy1, ack1, err1, lq1};
  endfunction

  task automatic drive(input bit sel, input logic rq, input logic [1:0] c,
                       input logic qf, input logic qbf);
    if (sel) begin
      req2 = rq; cmd2 = c; qf2 = qf; qbf2 = qbf;
    end else begin
      req1 = rq; cmd1 = c; qf1 = qf; qbf1 = qbf;
    end
  endtask

  task automatic run_cmd(input string tag, input bit sel,
                         input logic [1:0] c, input logic qf,
                         input logic qbf, input logic eerr,
                         input logic elq, input int su, input int pu);
    bit         legal;
    int         len;
    logic       es, er, een, prev;
    logic [6:0] e;
    legal = (c != 2'b00);
    len   = legal ? su + pu + 1 : 1;
    es    = legal ? c[1] : 1'b0;
    er    = legal ? c[0] : 1'b0;
    prev  = lqm[sel];
    // feedback is wrong except around the pulse, so early sampling shows
    @(negedge clk);
    drive(sel, 1'b1, c, ~qf, ~qbf);
    @(posedge clk);
    #1 drive(sel, 1'b0, c, ~qf, ~qbf);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      een = legal && (k > su) && (k <= su + pu);
      e = {(k < len) ? es : 1'b0, (k < len) ? er : 1'b0, een, 1'b1,
           (k == len), (k == len) ? eerr : 1'b0, prev};
      chk($sformatf("%s cyc%0d", tag, k), outs(sel), e);
      if (k >= su && k <= su + pu)
        drive(sel, 1'b0, c, qf, qbf);
      else
        drive(sel, 1'b0, c, ~qf, ~qbf);
    end
    @(negedge clk);
    chk($sformatf("%s idle", tag), outs(sel), {6'b0, elq});
    lqm[sel] = elq;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    lqm[0] = 1'b0;
    lqm[1] = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    #1 chk("reset async", outs(1'b0), 7'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset held", outs(1'b0), 7'b0);
    chk("reset held dut2", outs(1'b1), 7'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_cmd($sformatf("vec%0d", i), 1'b0, vecs[i].cmd, vecs[i].qf,
              vecs[i].qbf, vecs[i].eerr, vecs[i].elq, 1, 4);

    // req held high: accepts at 0, 7, 14
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("b2b cyc%0d", k), outs(1'b0),
          {(k % 7 >= 1) && (k % 7 <= 5), 1'b0,
           (k % 7 >= 2) && (k % 7 <= 5), (k % 7 != 0),
           (k % 7 == 6), 1'b0, 1'b1});
      if (k == 20) drive(1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("b2b stop", outs(1'b0), 7'b0000001);

    // async reset in the middle of a pulse cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre-abort", outs(1'b0), 7'b1011001);
    #2 rst = 1'b1;
    #1 chk("abort async", outs(1'b0), 7'b0);
    @(negedge clk);
    rst = 1'b0;
    lqm[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("no ack %0d", k), outs(1'b0), 7'b0);
    end
    run_cmd("post-rst", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1, 4);

    run_cmd("s3p1 set", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
    run_cmd("s3p1 rst", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
